// File: rtl/enc_frame_ctrl.sv
// enc_frame_ctrl
// Frame sequencer in front of the systematic block encoder.
//   - Accepts MSG_BEATS message words per codeword from a valid/ready source
//     and forwards them to the encoder on gen_valid/gen_data (registered).
//   - Holds the source off for PAR_BEATS cycles while the encoder emits parity.
//   - Produces codeword markers (valid/sop/par/eop) delayed by ENC_LAT cycles
//     so they line up with the encoder's enc_data output.
//   - Counts completed codewords in frm_cnt (wraps modulo 2^16).
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   src_valid/src_data    : upstream message word
//   src_ready             : controller can take a word this cycle
//   gen_valid/gen_data    : message beat to the encoder
//   out_valid/out_sop/out_par/out_eop : markers aligned to enc_data
//   frm_cnt               : completed codeword count
module enc_frame_ctrl #(
  parameter int ENC_SYM   = 2,
  parameter int EGF_DIM   = 8,
  parameter int MSG_BEATS = 12,
  parameter int PAR_BEATS = 4,
  parameter int ENC_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         src_valid,
  input  logic [ENC_SYM*EGF_DIM-1:0]   src_data,
  output logic                         src_ready,
  output logic                         gen_valid,
  output logic [ENC_SYM*EGF_DIM-1:0]   gen_data,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_par,
  output logic                         out_eop,
  output logic [15:0]                  frm_cnt
);

  localparam int W       = ENC_SYM * EGF_DIM;
  localparam int CNT_MAX = (MSG_BEATS > PAR_BEATS) ? MSG_BEATS : PAR_BEATS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST_MSG = CNT_W'(MSG_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_PAR = CNT_W'(PAR_BEATS - 1);

  // Marker vector layout: {valid, sop, par, eop}
  localparam logic [3:0] SLOT_NONE = 4'b0000;
  localparam logic [3:0] SLOT_SOP  = 4'b1100;
  localparam logic [3:0] SLOT_MSG  = 4'b1000;
  localparam logic [3:0] SLOT_PAR  = 4'b1010;
  localparam logic [3:0] SLOT_EOP  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               run_r;        // low until the first edge after reset release
  logic               gen_valid_r;
  logic [W-1:0]       gen_data_r;
  logic [3:0]         slot_r;
  logic [15:0]        frm_cnt_r;
  logic               accept_s;
  logic [3:0]         marker_s;

  // Ready depends only on state; run_r keeps it low while reset is held.
  assign src_ready = run_r && (state_r != ST_PAR);
  assign accept_s  = src_valid && src_ready;

  // Codeword sequencer: state, beat counter, encoder feed, slot markers and frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      run_r       <= 1'b0;
      gen_valid_r <= 1'b0;
      gen_data_r  <= '0;
      slot_r      <= SLOT_NONE;
      frm_cnt_r   <= 16'h0000;
    end else begin
      run_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            gen_valid_r <= 1'b1;
            gen_data_r  <= src_data;
            slot_r      <= SLOT_SOP;
            if (MSG_BEATS == 1) begin
              state_r <= ST_PAR;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_MSG;
              cnt_r   <= CNT_ONE;
            end
          end else begin
            gen_valid_r <= 1'b0;
            slot_r      <= SLOT_NONE;
          end
        end
        ST_MSG: begin
          if (accept_s) begin
            gen_valid_r <= 1'b1;
            gen_data_r  <= src_data;
            slot_r      <= SLOT_MSG;
            if (cnt_r == CNT_LAST_MSG) begin
              state_r <= ST_PAR;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            // Source gap: no slot, state and count hold, gen_data keeps last word.
            gen_valid_r <= 1'b0;
            slot_r      <= SLOT_NONE;
          end
        end
        ST_PAR: begin
          gen_valid_r <= 1'b0;
          if (cnt_r == CNT_LAST_PAR) begin
            slot_r    <= SLOT_EOP;
            frm_cnt_r <= frm_cnt_r + 16'h0001;
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
          end else begin
            slot_r <= SLOT_PAR;
            cnt_r  <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          gen_valid_r <= 1'b0;
          slot_r      <= SLOT_NONE;
        end
      endcase
    end
  end

  // Delay the slot markers by the encoder latency so they frame enc_data.
  generate
    if (ENC_LAT == 0) begin : g_no_pipe
      assign marker_s = slot_r;
    end else begin : g_pipe
      logic [3:0] pipe_r [ENC_LAT];

      // Marker delay line, cleared by reset together with the encoder.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ENC_LAT; i++) begin
            pipe_r[i] <= SLOT_NONE;
          end
        end else begin
          pipe_r[0] <= slot_r;
          for (int i = 1; i < ENC_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign marker_s = pipe_r[ENC_LAT-1];
    end
  endgenerate

  assign gen_valid = gen_valid_r;
  assign gen_data  = gen_data_r;
  assign out_valid = marker_s[3];
  assign out_sop   = marker_s[2];
  assign out_par   = marker_s[1];
  assign out_eop   = marker_s[0];
  assign frm_cnt   = frm_cnt_r;

endmodule

// File: tb/tb_enc_frame_ctrl.sv
// Scoreboard bench for enc_frame_ctrl. Three instances (ENC_LAT = 0, 1, 3)
// share the same stimulus; the stimulus pushes expected marker slots (with the
// cycle they must appear) into per-instance queues, and monitors pop/compare.
module tb_enc_frame_ctrl;

  typedef struct packed {
    int         cyc;
    logic [3:0] f;     // {valid, sop, par, eop}
  } mk_t;

  typedef struct packed {
    int          cyc;
    logic [15:0] d;
  } gd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_valid = 1'b0;
  logic [15:0] src_data = 16'h0000;

  logic        rdy [3];
  logic        gv  [3];
  logic [15:0] gd  [3];
  logic        ov  [3];
  logic        os  [3];
  logic        op  [3];
  logic        oe  [3];
  logic [15:0] frm [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mk_t q0[$];
  mk_t q1[$];
  mk_t q2[$];
  gd_t qg[$];

  logic [15:0] exp_frm [3];
  logic [15:0] words [4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  enc_frame_ctrl #(.ENC_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(rdy[0]), .gen_valid(gv[0]), .gen_data(gd[0]),
    .out_valid(ov[0]), .out_sop(os[0]), .out_par(op[0]), .out_eop(oe[0]),
    .frm_cnt(frm[0]));

  enc_frame_ctrl #(.ENC_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(rdy[1]), .gen_valid(gv[1]), .gen_data(gd[1]),
    .out_valid(ov[1]), .out_sop(os[1]), .out_par(op[1]), .out_eop(oe[1]),
    .frm_cnt(frm[1]));

  enc_frame_ctrl #(.ENC_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(rdy[2]), .gen_valid(gv[2]), .gen_data(gd[2]),
    .out_valid(ov[2]), .out_sop(os[2]), .out_par(op[2]), .out_eop(oe[2]),
    .frm_cnt(frm[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_mk(input string nm, input logic [3:0] act, input logic have, input mk_t e);
    if (!have) begin
      chk({nm, "_unexpected"}, {28'd0, act}, 32'd0);
    end else begin
      chk({nm, "_flags"}, {28'd0, act}, {28'd0, e.f});
      chk({nm, "_cycle"}, cyc, e.cyc);
    end
  endtask

  // Marker monitors, one per instance.
  always @(negedge clk) begin
    mk_t e;
    logic have;
    if ({ov[0], os[0], op[0], oe[0]} != 4'b0000) begin
      have = (q0.size() > 0);
      e = '0;
      if (have) e = q0.pop_front();
      cmp_mk("mk_lat0", {ov[0], os[0], op[0], oe[0]}, have, e);
    end
  end

  always @(negedge clk) begin
    mk_t e;
    logic have;
    if ({ov[1], os[1], op[1], oe[1]} != 4'b0000) begin
      have = (q1.size() > 0);
      e = '0;
      if (have) e = q1.pop_front();
      cmp_mk("mk_lat1", {ov[1], os[1], op[1], oe[1]}, have, e);
    end
  end

  always @(negedge clk) begin
    mk_t e;
    logic have;
    if ({ov[2], os[2], op[2], oe[2]} != 4'b0000) begin
      have = (q2.size() > 0);
      e = '0;
      if (have) e = q2.pop_front();
      cmp_mk("mk_lat3", {ov[2], os[2], op[2], oe[2]}, have, e);
    end
  end

  // Encoder-feed monitor on the ENC_LAT=1 instance.
  always @(negedge clk) begin
    gd_t e;
    if (gv[1]) begin
      if (qg.size() == 0) begin
        chk("gen_unexpected", {31'd0, gv[1]}, 32'd0);
      end else begin
        e = qg.pop_front();
        chk("gen_data", {16'd0, gd[1]}, {16'd0, e.d});
        chk("gen_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_mk(input int e, input logic [3:0] f);
    q0.push_back('{cyc: e,     f: f});
    q1.push_back('{cyc: e + 1, f: f});
    q2.push_back('{cyc: e + 3, f: f});
  endtask

  task automatic chk_ready(input logic exp);
    for (int i = 0; i < 3; i++) chk($sformatf("src_ready%0d", i), {31'd0, rdy[i]}, {31'd0, exp});
  endtask

  task automatic chk_frm();
    for (int i = 0; i < 3; i++) chk($sformatf("frm_cnt%0d", i), {16'd0, frm[i]}, {16'd0, exp_frm[i]});
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rdy%0d", tag, i), {31'd0, rdy[i]}, 32'd0);
      chk($sformatf("%s_gv%0d", tag, i), {31'd0, gv[i]}, 32'd0);
      chk($sformatf("%s_gd%0d", tag, i), {16'd0, gd[i]}, 32'd0);
      chk($sformatf("%s_out%0d", tag, i), {28'd0, ov[i], os[i], op[i], oe[i]}, 32'd0);
      chk($sformatf("%s_frm%0d", tag, i), {16'd0, frm[i]}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    src_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One codeword: stop_at message beats (12 = full codeword, fewer = aborted
  // before parity), with a gap of gap_len cycles inserted before beat gap_at.
  task automatic send_frame(input int gap_at, input int gap_len, input int stop_at);
    int e;
    e = 0;
    for (int b = 0; b < stop_at; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          chk_ready(1'b1);
          src_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      chk_ready(1'b1);
      src_valid = 1'b1;
      src_data  = words[b % 4];
      @(posedge clk);
      #1;
      e = cyc;
      qg.push_back('{cyc: e, d: words[b % 4]});
      push_mk(e, {1'b1, (b == 0), 1'b0, 1'b0});
    end
    if (stop_at == 12) begin
      // Parity slots: source stays valid with junk that must not be taken.
      for (int p = 0; p < 4; p++) begin
        chk_ready(1'b0);
        src_valid = 1'b1;
        src_data  = 16'hdead;
        push_mk(e + 1 + p, {1'b1, 1'b0, 1'b1, (p == 3)});
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 3; i++) exp_frm[i] = exp_frm[i] + 16'h0001;
    end
  endtask

  // Drop expectations that an asynchronous reset asserted now will wipe out.
  task automatic flush_pending();
    while (q0.size() > 0 && q0[q0.size()-1].cyc >= cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1].cyc >= cyc) void'(q1.pop_back());
    while (q2.size() > 0 && q2[q2.size()-1].cyc >= cyc) void'(q2.pop_back());
    while (qg.size() > 0 && qg[qg.size()-1].cyc >= cyc) void'(qg.pop_back());
  endtask

  initial begin
    words[0] = 16'h0123;
    words[1] = 16'h4567;
    words[2] = 16'h89ab;
    words[3] = 16'hcdef;
    for (int i = 0; i < 3; i++) exp_frm[i] = 16'h0000;

    // Reset held, then released with the source idle.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    idle(10);
    chk_ready(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("idle_gv%0d", i), {31'd0, gv[i]}, 32'd0);
      chk($sformatf("idle_out%0d", i), {28'd0, ov[i], os[i], op[i], oe[i]}, 32'd0);
    end
    chk_frm();

    // Single continuous codeword.
    send_frame(99, 0, 12);
    chk_frm();
    idle(3);

    // Codeword with a 3-cycle source gap after beat 5.
    send_frame(5, 3, 12);
    chk_frm();
    idle(2);

    // Three back-to-back codewords, source always valid.
    send_frame(99, 0, 12);
    send_frame(99, 0, 12);
    send_frame(99, 0, 12);
    chk_frm();
    idle(2);

    // Reset in the middle of a message after beat 7.
    send_frame(99, 0, 7);
    rst_n = 1'b0;
    flush_pending();
    #1;
    chk_all_zero("mid_reset");
    repeat (5) @(posedge clk);
    #1;
    chk_all_zero("mid_reset_hold");
    for (int i = 0; i < 3; i++) exp_frm[i] = 16'h0000;
    rst_n = 1'b1;
    idle(1);
    send_frame(99, 0, 12);
    chk_frm();
    idle(2);

    // Frame counter wrap on the ENC_LAT=1 instance.
    force u_lat1.frm_cnt_r = 16'hffff;
    #1;
    release u_lat1.frm_cnt_r;
    #1;
    chk("frm_cnt_preload", {16'd0, frm[1]}, 32'h0000ffff);
    exp_frm[1] = 16'hffff;
    @(posedge clk);
    #1;
    send_frame(99, 0, 12);
    chk("frm_cnt_wrap", {16'd0, frm[1]}, 32'h00000000);
    chk_frm();

    // Drain: every expected slot must have been presented.
    idle(8);
    chk("q_lat0_empty", q0.size(), 0);
    chk("q_lat1_empty", q1.size(), 0);
    chk("q_lat3_empty", q2.size(), 0);
    chk("q_gen_empty", qg.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
